display_scan_controller: RTL and testbench
==========================================

DISPLAY_SCAN_CONTROLLER -- requirements
Module: display_scan_controller

Interface
REQ-001 Parameter REFRESH_DIV, default 50000, SHOW-phase length per digit, in clk cycles (≥1).
REQ-002 Parameter BLANK_CYCLES, default 500, all-anodes-off guard interval before each digit, in clk cycles (≥1).
REQ-003 Parameter BLINK_FRAMES, default 64, frames per blink half-period; used only when BLINK_EN is defined.
REQ-004 The module SHALL have one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 enable  input  1  1 = scanning runs; 0 = display dark.
REQ-008 digits  input  24  six BCD digits; [3:0] = digit 0 (seconds units) … [23:20] = digit 5 (hours tens).
REQ-009 blank_mask  input  6  bit i = 1 keeps digit i dark (e.g. leading-zero hours).
REQ-010 digit_out  output  4  BCD value to the shared seven-segment decoder.
REQ-011 anode_n  output  6  active-low digit select; at most one bit low.
REQ-012 frame_done  output  1  one-cycle pulse when digit 5 completes SHOW.
REQ-013 blink_mask  input  6  present only with BLINK_EN; bit i = 1 makes digit i blink.

Function
REQ-014 FSM states: IDLE, BLANK, SHOW; all outputs registered.
REQ-015 IDLE: anode_n = 6'b111111, digit_out = 4'hF; enable = 1 -> BLANK with idx = 0.
REQ-016 BLANK: anode_n all 1; after exactly BLANK_CYCLES cycles -> SHOW.
REQ-017 SHOW: anode_n[idx] = 0 unless blank_mask[idx] = 1 (then all 1); digit_out = snapshot digit idx; after exactly REFRESH_DIV cycles -> BLANK with idx+1.
REQ-018 idx wraps 5 -> 0; frame_done = 1 on the cycle SHOW of digit 5 ends; 0 otherwise.
REQ-019 digits SHALL be snapshotted into an internal 24-bit register on entry to BLANK with idx = 0; changes mid-frame are not shown until the next frame (no tearing).
REQ-020 Snapshot nibble > 9 SHALL drive digit_out = 4'hF (decoder default: dark).
REQ-021 blank_mask and blink_mask are sampled live each cycle, not snapshotted.
REQ-022 Outputs in BLANK and IDLE: digit_out = 4'hF.
REQ-023 enable deasserted in any state -> IDLE on the next edge; anodes all 1 that cycle; no frame_done; resume restarts at idx 0 with fresh snapshot.
REQ-024 Phase counter width = clog2(max(REFRESH_DIV, BLANK_CYCLES)); counter clears on every state change.
REQ-025 Frame period = 6 × (BLANK_CYCLES + REFRESH_DIV) cycles exactly.

Reset
REQ-026 reset SHALL override enable: state IDLE, idx 0, counter 0, snapshot 0, anode_n 6'b111111, digit_out 4'hF, frame_done 0 (blink phase 0, blink frame counter 0 with BLINK_EN).
REQ-027 reset asserted mid-SHOW SHALL darken all anodes on the same edge.

Configuration
REQ-028 Macro DISPLAY_BLINK_EN: when defined, blink_mask port and a frame counter exist; blink phase toggles every BLINK_FRAMES frame_done pulses; during phase 1, digits with blink_mask[i] = 1 are dark in SHOW.
REQ-029 Without DISPLAY_BLINK_EN: no blink_mask port, no blink logic; behaviour identical to BLINK_EN build with blink_mask = 0.

Verification (REFRESH_DIV = 4, BLANK_CYCLES = 2, BLINK_FRAMES = 2)
REQ-030 reset, enable = 1, digits = 24'h123456, blank_mask = 0 -> anode_n cycles 111110 (digit_out 6), 111101 (5) … 011111 (1); each low for 4 cycles, separated by 2 dark cycles; frame_done after 36 cycles.
REQ-031 digits changed to 24'h000000 during digit 2 SHOW -> current frame still shows 3,2,1 for digits 3-5; next frame shows 0s.
REQ-032 blank_mask = 6'b100000, digits = 24'h012345 -> digit 5 slot all anodes high; other digits normal; frame period unchanged at 36.
REQ-033 digits nibble 0 = 4'hB -> digit_out = 4'hF during digit 0 SHOW, anode_n = 111110.
REQ-034 enable dropped mid-SHOW of digit 3, re-raised 5 cycles later -> anodes 111111 next edge, no frame_done; restart at digit 0 after 2 BLANK cycles; reset mid-SHOW likewise darkens on the same edge.
REQ-035 DISPLAY_BLINK_EN, blink_mask = 6'b000011 -> digits 0-1 lit frames 1-2, dark frames 3-4, lit frames 5-6; digits 2-5 always lit.

Source files
------------

// File: rtl/display_scan_controller.sv
// display_scan_controller: time-multiplexed six-digit seven-segment scanner.
// Each digit gets a dark guard interval (BLANK) followed by a lit interval (SHOW).
// The digit values are latched once per frame so a frame never mixes old and new time.
// Optional build macro: DISPLAY_BLINK_EN adds blink_mask and a frame-based blink phase.
module display_scan_controller #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [23:0] digits,
  input  logic [5:0]  blank_mask,
`ifdef DISPLAY_BLINK_EN
  input  logic [5:0]  blink_mask,
`endif
  output logic [3:0]  digit_out,
  output logic [5:0]  anode_n,
  output logic        frame_done
);

  localparam int MAXC = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [23:0] snap_q, snap_d;
  logic [5:0]  anode_d;
  logic [3:0]  digit_d;
  logic        fdone_d;
  logic        dark_slot;

  // Nibbles above 9 are not BCD; send the decoder its dark code instead.
  function automatic logic [3:0] bcd_or_dark(input logic [3:0] nib);
    return (nib > 4'd9) ? 4'hF : nib;
  endfunction

`ifdef DISPLAY_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic          blink_ph_q, blink_ph_d;
  logic [FW-1:0] fcnt_q, fcnt_d;

  // Blink phase toggles after every BLINK_FRAMES completed frames.
  always_comb begin
    blink_ph_d = blink_ph_q;
    fcnt_d     = fcnt_q;
    if (fdone_d) begin
      if (fcnt_q == FW'(BLINK_FRAMES - 1)) begin
        fcnt_d     = '0;
        blink_ph_d = ~blink_ph_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  // Blink state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_ph_q <= 1'b0;
      fcnt_q     <= '0;
    end else begin
      blink_ph_q <= blink_ph_d;
      fcnt_q     <= fcnt_d;
    end
  end

  assign dark_slot = blank_mask[idx_d] | (blink_ph_q & blink_mask[idx_d]);
`else
  assign dark_slot = blank_mask[idx_d];
`endif

  // Next-state logic; outputs are derived from the next state so they register in step with it.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + 1'b1;
    snap_d  = snap_q;
    if (!enable) begin
      state_d = IDLE;
      idx_d   = 3'd0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = BLANK;
          idx_d   = 3'd0;
          cnt_d   = '0;
        end
        BLANK: begin
          if (cnt_q == CW'(BLANK_CYCLES - 1)) begin
            state_d = SHOW;
            cnt_d   = '0;
          end
        end
        SHOW: begin
          if (cnt_q == CW'(REFRESH_DIV - 1)) begin
            state_d = BLANK;
            idx_d   = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = 3'd0;
          cnt_d   = '0;
        end
      endcase
    end
    // Latch a fresh frame of digits only when a new frame starts.
    if (state_d == BLANK && idx_d == 3'd0 && state_q != BLANK)
      snap_d = digits;

    anode_d = 6'b111111;
    digit_d = 4'hF;
    fdone_d = 1'b0;
    if (state_d == SHOW) begin
      digit_d = bcd_or_dark(snap_d[{idx_d, 2'b00} +: 4]);
      if (!dark_slot)
        anode_d = ~(6'b000001 << idx_d);
      fdone_d = (idx_d == 3'd5) && (cnt_d == CW'(REFRESH_DIV - 1));
    end
  end

  // State, snapshot and registered outputs; reset darkens the display on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= 3'd0;
      cnt_q      <= '0;
      snap_q     <= '0;
      anode_n    <= 6'b111111;
      digit_out  <= 4'hF;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      snap_q     <= snap_d;
      anode_n    <= anode_d;
      digit_out  <= digit_d;
      frame_done <= fdone_d;
    end
  end

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller with REFRESH_DIV=4, BLANK_CYCLES=2.
module tb_display_scan_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [23:0] digits;
  logic [5:0]  blank_mask;
  logic [3:0]  digit_out;
  logic [5:0]  anode_n;
  logic        frame_done;
`ifdef DISPLAY_BLINK_EN
  logic [5:0]  blink_mask = 6'b0;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  display_scan_controller #(
    .REFRESH_DIV(4),
    .BLANK_CYCLES(2),
    .BLINK_FRAMES(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .digits(digits),
    .blank_mask(blank_mask),
`ifdef DISPLAY_BLINK_EN
    .blink_mask(blink_mask),
`endif
    .digit_out(digit_out),
    .anode_n(anode_n),
    .frame_done(frame_done)
  );

  // Expected {anode_n, digit_out, frame_done} at position pos (0..35) of a 36-cycle frame.
  function automatic logic [10:0] exp_at(input int pos, input logic [23:0] d, input logic [5:0] bm);
    int slot;
    logic [3:0] nib;
    logic [5:0] an;
    slot = pos / 6;
    if ((pos % 6) < 2) return {6'b111111, 4'hF, 1'b0};
    nib = d[slot*4 +: 4];
    if (nib > 4'd9) nib = 4'hF;
    an = bm[slot] ? 6'b111111 : ~(6'b000001 << slot);
    return {an, nib, (pos == 35)};
  endfunction

  // Holds reset for two cycles, then releases with the given inputs; next negedge is frame pos 0.
  task automatic start(input logic [23:0] d, input logic [5:0] bm);
    reset = 1'b1; enable = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0; enable = 1'b1; digits = d; blank_mask = bm;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; digits = 24'h123456; blank_mask = 6'b0;
    @(negedge clk); @(negedge clk);
    total++;
    if ({anode_n, digit_out, frame_done} !== {6'b111111, 4'hF, 1'b0}) begin
      bad++;
      $display("FAIL reset_state got=%h want=%h", {anode_n, digit_out, frame_done}, {6'b111111, 4'hF, 1'b0});
    end
  endtask

  task automatic test_scan();
    logic [10:0] want;
    start(24'h123456, 6'b0);
    for (int k = 0; k < 72; k++) begin
      @(negedge clk);
      want = exp_at(k % 36, 24'h123456, 6'b0);
      total++;
      if ({anode_n, digit_out, frame_done} !== want) begin
        bad++;
        $display("FAIL scan k=%0d got=%h want=%h", k, {anode_n, digit_out, frame_done}, want);
      end
    end
  endtask

  task automatic test_snapshot();
    logic [10:0] want;
    start(24'h123456, 6'b0);
    for (int k = 0; k < 72; k++) begin
      @(negedge clk);
      want = (k < 36) ? exp_at(k, 24'h123456, 6'b0) : exp_at(k - 36, 24'h000000, 6'b0);
      total++;
      if ({anode_n, digit_out, frame_done} !== want) begin
        bad++;
        $display("FAIL snapshot k=%0d got=%h want=%h", k, {anode_n, digit_out, frame_done}, want);
      end
      if (k == 13) digits = 24'h000000;
    end
  endtask

  task automatic test_blank_mask();
    logic [10:0] want;
    start(24'h012345, 6'b100000);
    for (int k = 0; k < 36; k++) begin
      @(negedge clk);
      want = exp_at(k, 24'h012345, 6'b100000);
      total++;
      if ({anode_n, digit_out, frame_done} !== want) begin
        bad++;
        $display("FAIL blank_mask k=%0d got=%h want=%h", k, {anode_n, digit_out, frame_done}, want);
      end
    end
    blank_mask = 6'b0;
  endtask

  task automatic test_invalid_bcd();
    start(24'h12345B, 6'b0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        total++;
        if ({anode_n, digit_out} !== {6'b111110, 4'hF}) begin
          bad++;
          $display("FAIL invalid_bcd k=%0d got=%h want=%h", k, {anode_n, digit_out}, {6'b111110, 4'hF});
        end
      end
    end
  endtask

  task automatic test_enable_drop();
    logic [10:0] want;
    start(24'h123456, 6'b0);
    for (int k = 0; k < 22; k++) @(negedge clk);
    enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++;
      if ({anode_n, digit_out, frame_done} !== {6'b111111, 4'hF, 1'b0}) begin
        bad++;
        $display("FAIL enable_drop k=%0d got=%h want=%h", k, {anode_n, digit_out, frame_done}, {6'b111111, 4'hF, 1'b0});
      end
    end
    enable = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      want = exp_at(k, 24'h123456, 6'b0);
      total++;
      if ({anode_n, digit_out, frame_done} !== want) begin
        bad++;
        $display("FAIL enable_resume k=%0d got=%h want=%h", k, {anode_n, digit_out, frame_done}, want);
      end
    end
  endtask

  task automatic test_reset_mid_show();
    logic [10:0] want;
    start(24'h123456, 6'b0);
    for (int k = 0; k < 10; k++) @(negedge clk);
    total++;
    if (anode_n !== 6'b111101) begin
      bad++;
      $display("FAIL pre_reset_lit got=%h want=%h", anode_n, 6'b111101);
    end
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({anode_n, digit_out, frame_done} !== {6'b111111, 4'hF, 1'b0}) begin
      bad++;
      $display("FAIL reset_mid_show got=%h want=%h", {anode_n, digit_out, frame_done}, {6'b111111, 4'hF, 1'b0});
    end
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      want = exp_at(k, 24'h123456, 6'b0);
      total++;
      if ({anode_n, digit_out, frame_done} !== want) begin
        bad++;
        $display("FAIL reset_resume k=%0d got=%h want=%h", k, {anode_n, digit_out, frame_done}, want);
      end
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; digits = 24'h0; blank_mask = 6'b0;
    test_reset();
    test_scan();
    test_snapshot();
    test_blank_mask();
    test_invalid_bcd();
    test_enable_drop();
    test_reset_mid_show();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
